// File: rtl/sys_mem_port_if.sv
// Cache-controller and memory-bus signals of the system memory port.
// The slave modport is the port itself; master is its environment.
interface sys_mem_port_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  SysStrobe;
   logic                  SysRW;
   logic [ADDR_WIDTH-1:0] SysAddr;
   logic [DATA_WIDTH-1:0] SysDataIn;
   logic [DATA_WIDTH-1:0] SysDataOut;
   logic                  wait_state_ctr_carry;
   logic                  sys_busy;
   logic                  mem_cs;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;

   modport slave (
      input  SysStrobe, SysRW, SysAddr, SysDataIn, mem_rdata, mem_ready,
      output SysDataOut, wait_state_ctr_carry, sys_busy,
             mem_cs, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output SysStrobe, SysRW, SysAddr, SysDataIn, mem_rdata, mem_ready,
      input  SysDataOut, wait_state_ctr_carry, sys_busy,
             mem_cs, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sys_mem_port.sv
// System-side memory port: runs one cache transaction on the memory bus for a
// fixed number of wait states and pulses wait_state_ctr_carry on completion.
module sys_mem_port #(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int WAIT_STATES = 4
) (
   input  logic           clock,
   input  logic           reset,
   sys_mem_port_if.slave  bus
);
   localparam int CNT_W = $clog2(WAIT_STATES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_STATES - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_cs;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  w_carry;

   // NOTE: carry is a plain continuous assign of registered state and
   // mem_ready, so the controller sees it in the same cycle the last wait
   // state meets a ready memory.
   assign w_carry = (r_state == S_WAIT) && (r_cnt == LAST_CNT) && bus.mem_ready;

   // NOTE: all state updates below are non-blocking so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_data_out <= '0;
         r_cs       <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.SysStrobe) begin
                  r_addr  <= bus.SysAddr;
                  r_wdata <= bus.SysDataIn;
                  r_cs    <= 1'b1;
                  r_we    <= ~bus.SysRW;
                  r_cnt   <= '0;
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt != LAST_CNT) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else if (bus.mem_ready) begin
                  r_state <= S_IDLE;
                  r_cs    <= 1'b0;
                  r_we    <= 1'b0;
                  // r_we still holds the transaction direction on this edge
                  if (!r_we) r_data_out <= bus.mem_rdata;
               end
            end
         endcase
      end
   end

   assign bus.SysDataOut           = r_data_out;
   assign bus.wait_state_ctr_carry = w_carry;
   assign bus.sys_busy             = (r_state != S_IDLE);
   assign bus.mem_cs               = r_cs;
   assign bus.mem_we               = r_we;
   assign bus.mem_addr             = r_addr;
   assign bus.mem_wdata            = r_wdata;
endmodule
